// File: rtl/div_unit.sv
// Multi-cycle signed 32-bit restoring divider: 32 CALC steps, one SIGN fix-up, one DONE pulse.
// Optional macro DIV_ZERO_TRAP_EN: a zero divisor skips CALC and raises div0 with done.
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        divControl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div0
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    rem_q;
    logic [W-1:0]    quo_q;
    logic [W-1:0]    babs_q;
    logic            asign_q;
    logic            qsign_q;
    logic [W-1:0]    hi_q;
    logic [W-1:0]    lo_q;
    logic            busy_q;
    logic            done_q;

    logic [W-1:0]    a_abs_c;
    logic [W-1:0]    b_abs_c;
    logic [W:0]      rem_sh_c;
    logic            fits_c;
    logic [W-1:0]    rem_d;
    logic [W-1:0]    quo_d;
    logic            b_zero_c;

    assign a_abs_c = a[W-1] ? W'(~a + W'(1)) : a;
    assign b_abs_c = b[W-1] ? W'(~b + W'(1)) : b;

`ifdef DIV_ZERO_TRAP_EN
    logic div0_q;
    assign b_zero_c = (b == '0);
    assign div0     = div0_q;
`else
    assign b_zero_c = 1'b0;
    assign div0     = 1'b0;
`endif

    // One restoring step: shift {rem, quo} left, trial-subtract |b| with a 33-bit compare.
    always_comb begin
        rem_sh_c = {rem_q, quo_q[W-1]};
        fits_c   = (rem_sh_c >= {1'b0, babs_q});
        rem_d    = fits_c ? W'(rem_sh_c - {1'b0, babs_q}) : rem_sh_c[W-1:0];
        quo_d    = {quo_q[W-2:0], fits_c};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            babs_q  <= '0;
            asign_q <= 1'b0;
            qsign_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
            div0_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (divControl && b_zero_c) begin
                        state_q <= DONE;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b1;
`ifdef DIV_ZERO_TRAP_EN
                        div0_q  <= 1'b1;
`endif
                    end else if (divControl) begin
                        state_q <= CALC;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        rem_q   <= '0;
                        quo_q   <= a_abs_c;
                        babs_q  <= b_abs_c;
                        asign_q <= a[W-1];
                        qsign_q <= a[W-1] ^ b[W-1];
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) begin
                        state_q <= SIGN;
                    end
                end
                SIGN: begin
                    lo_q    <= qsign_q ? W'(~quo_q + W'(1)) : quo_q;
                    hi_q    <= asign_q ? W'(~rem_q + W'(1)) : rem_q;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
`ifdef DIV_ZERO_TRAP_EN
                    div0_q  <= 1'b0;
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table plus random vectors through a result
// queue, and hand sequences for abort, ignored restart, back-to-back start and zero divisor.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        divControl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        div0;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[12];
    logic [31:0] last_lo;
    logic [31:0] last_hi;

    div_unit dut (
        .clk        (clk),
        .reset      (reset),
        .divControl (divControl),
        .a          (a),
        .b          (b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div0       (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent reference: 64-bit signed arithmetic, truncating toward zero.
    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv);
        exp_t   e;
        longint sa, sbv, q, r;
        sa  = longint'($signed(av));
        sbv = longint'($signed(bv));
        e.div0 = 1'b0;
        if (sbv == 0) begin
            e.lo = av[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
            e.hi = av;
        end else begin
            q = sa / sbv;
            r = sa % sbv;
            e.lo = q[31:0];
            e.hi = r[31:0];
        end
        return e;
    endfunction

    task automatic push_exp(input logic [31:0] elo, input logic [31:0] ehi, input logic ediv0);
        exp_t e;
        e.lo = elo;
        e.hi = ehi;
        e.div0 = ediv0;
        sb.push_back(e);
    endtask

    task automatic drive_start(input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        divControl = 1'b1;
        a = av;
        b = bv;
        @(posedge clk);
        #1;
        divControl = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    // Wait for done, pop the expected result and compare; optionally poke a start mid-run.
    task automatic wait_done(input int exp_lat, input int poke_at);
        int   n;
        int   busy_n;
        bit   seen;
        exp_t e;
        n = 0;
        busy_n = 0;
        seen = 0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (busy) busy_n++;
            if (poke_at != 0 && n == poke_at) begin
                divControl = 1'b1;
                a = 32'd1;
                b = 32'd1;
            end else if (poke_at != 0 && n == poke_at + 1) begin
                divControl = 1'b0;
            end
            if (done) seen = 1;
        end
        chk("done_latency", 32'(n), 32'(exp_lat));
        chk("busy_cycles", 32'(busy_n), 32'(exp_lat));
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard: done with empty queue lo=%h hi=%h", lo, hi);
        end else begin
            e = sb.pop_front();
            if (seen) begin
                chk("lo", lo, e.lo);
                chk("hi", hi, e.hi);
                chk("div0", 32'(div0), 32'(e.div0));
            end
            last_lo = e.lo;
            last_hi = e.hi;
        end
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("div0_after_done", 32'(div0), 32'd0);
    endtask

    task automatic run_model(input logic [31:0] av, input logic [31:0] bv);
        exp_t e;
        e = model(av, bv);
        sb.push_back(e);
        drive_start(av, bv);
        wait_done(34, 0);
    endtask

    initial begin
        int n_done;
        reset = 1'b0;
        divControl = 1'b0;
        a = '0;
        b = '0;
        last_lo = '0;
        last_hi = '0;

        vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1]  = '{32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2]  = '{32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
        vecs[3]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
        vecs[4]  = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};
        vecs[5]  = '{32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          32'hFFFF_FFFF};
        vecs[6]  = '{32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF,  32'd0};
        vecs[7]  = '{32'd0,          32'd5,          32'd0,          32'd0};
        vecs[8]  = '{32'h00BC_614E,  32'h0000_0100,  32'h0000_BC61,  32'h0000_004E};
        vecs[9]  = '{32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0};
        vecs[10] = '{32'd5,          32'd100,        32'd0,          32'd5};
        vecs[11] = '{32'hFFFF_FFFB,  32'd100,        32'd0,          32'hFFFF_FFFB};

        // Reset, with a start request in the same cycle that must lose to reset.
        repeat (2) @(negedge clk);
        divControl = 1'b1;
        a = 32'd9;
        b = 32'd3;
        @(negedge clk);
        divControl = 1'b0;
        reset = 1'b1;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_div0", 32'(div0), 32'd0);

        foreach (vecs[i]) begin
            push_exp(vecs[i].lo, vecs[i].hi, 1'b0);
            drive_start(vecs[i].a, vecs[i].b);
            wait_done(34, 0);
        end

        for (int i = 0; i < 16; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i < 8) ? $urandom : 32'($urandom_range(1, 300));
            if (i >= 8 && $urandom_range(0, 1) == 1) rb = 32'(~rb + 32'd1);
            if (rb == 32'd0) rb = 32'd3;
            run_model(ra, rb);
        end

        // A second start while busy is ignored.
        push_exp(32'd14, 32'd2, 1'b0);
        drive_start(32'd100, 32'd7);
        wait_done(34, 5);

        // Start held high through DONE: next accept only from IDLE, one idle cycle later.
        push_exp(32'd14, 32'd2, 1'b0);
        push_exp(32'd16, 32'd2, 1'b0);
        @(negedge clk);
        divControl = 1'b1;
        a = 32'd100;
        b = 32'd7;
        @(posedge clk);
        #1;
        a = 32'd50;
        b = 32'd3;
        wait_done(34, 0);
        @(posedge clk);
        #1;
        divControl = 1'b0;
        wait_done(34, 0);

        // Zero divisor.
`ifdef DIV_ZERO_TRAP_EN
        push_exp(last_lo, last_hi, 1'b1);
        drive_start(32'd7, 32'd0);
        wait_done(1, 0);
`else
        run_model(32'd7, 32'd0);
        push_exp(32'd1, 32'hFFFF_FFF9, 1'b0);
        drive_start(32'hFFFF_FFF9, 32'd0);
        wait_done(34, 0);
`endif

        // Abort mid-CALC: reset clears everything, no done pulse follows.
        drive_start(32'd100, 32'd7);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        chk("abort_no_done", 32'(n_done), 32'd0);

        run_model(32'h8000_0000, 32'hFFFF_FFFF);

        chk("queue_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
